input_debouncer: RTL and testbench

- Multi-channel synchroniser plus debouncer for raw asynchronous inputs (push-buttons, switches).
- Sits directly upstream of the edge-detection stage: its clean, clk-synchronous signal_out drives the edge detector's signal_in.
- Removes contact bounce: an output bit changes only after the synchronised input has held the new level for STABLE_CYCLES consecutive clocks.

---
 rtl/input_debouncer_if.sv | 14 +
 rtl/input_debouncer.sv | 49 ++++
 tb/tb_input_debouncer.sv | 127 ++++++++++++
 3 files changed

// File: rtl/input_debouncer_if.sv
// input_debouncer_if: raw inputs toward the debouncer, clean levels (and per-channel busy
// when INPUT_DEBOUNCER_BUSY_EN is defined) back out.
interface input_debouncer_if #(parameter int WIDTH = 2);
  logic [WIDTH-1:0] signal_in;
  logic [WIDTH-1:0] signal_out;
`ifdef INPUT_DEBOUNCER_BUSY_EN
  logic [WIDTH-1:0] busy;
  modport master(output signal_in, input signal_out, input busy);
  modport slave(input signal_in, output signal_out, output busy);
`else
  modport master(output signal_in, input signal_out);
  modport slave(input signal_in, output signal_out);
`endif
endinterface

// File: rtl/input_debouncer.sv
// input_debouncer: per-channel synchroniser plus STABLE_CYCLES debounce counter.
// Optional INPUT_DEBOUNCER_BUSY_EN exposes a per-channel "counting" flag.
module input_debouncer #(
  parameter int WIDTH = 2,
  parameter int SYNC_STAGES = 2,
  parameter int STABLE_CYCLES = 1000
) (
  input logic clk,
  input logic async_nreset,
  input_debouncer_if.slave bus
);
  localparam int CW = $clog2(STABLE_CYCLES + 1);
  typedef enum logic {STABLE, COUNTING} state_t;
  for (genvar i = 0; i < WIDTH; i++) begin : g_ch
    logic [SYNC_STAGES-1:0] sync;
    logic [CW-1:0] cnt;
    logic out;
    logic s;
    state_t state;
    assign s = sync[SYNC_STAGES-1];
    always_ff @(posedge clk or negedge async_nreset)
      if (!async_nreset) begin
        sync <= '0;
        cnt <= '0;
        out <= 1'b0;
        state <= STABLE;
      end else begin
        sync <= {sync[SYNC_STAGES-2:0], bus.signal_in[i]};
        if (state == STABLE) begin
          // a single differing sample suffices when STABLE_CYCLES is 1
          if (s != out) begin
            if (STABLE_CYCLES == 1) out <= s;
            else begin
              cnt <= CW'(1);
              state <= COUNTING;
            end
          end
        end else if (s == out || cnt == CW'(STABLE_CYCLES - 1)) begin
          if (s != out) out <= s;
          cnt <= '0;
          state <= STABLE;
        end else cnt <= cnt + 1'b1;
      end
    assign bus.signal_out[i] = out;
`ifdef INPUT_DEBOUNCER_BUSY_EN
    assign bus.busy[i] = (state == COUNTING);
`endif
  end
endmodule

// File: tb/tb_input_debouncer.sv
// tb_input_debouncer: directed checks of a STABLE_CYCLES=4 and a STABLE_CYCLES=1 debouncer.
module tb_input_debouncer;
  logic clk = 1'b0;
  logic async_nreset = 1'b0;
  int n_vec = 0;
  int n_err = 0;
  input_debouncer_if #(.WIDTH(2)) bus_a();
  input_debouncer_if #(.WIDTH(2)) bus_b();
  input_debouncer #(.WIDTH(2), .SYNC_STAGES(2), .STABLE_CYCLES(4)) dut_a (
    .clk(clk), .async_nreset(async_nreset), .bus(bus_a.slave));
  input_debouncer #(.WIDTH(2), .SYNC_STAGES(2), .STABLE_CYCLES(1)) dut_b (
    .clk(clk), .async_nreset(async_nreset), .bus(bus_b.slave));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end
  initial begin
    int rises;
    logic prev;
    bus_a.signal_in = 2'b00;
    bus_b.signal_in = 2'b00;
    #22;
    check("reset out_a", bus_a.signal_out, 2'b00);
    check("reset out_b", bus_b.signal_out, 2'b00);
`ifdef INPUT_DEBOUNCER_BUSY_EN
    check("reset busy_a", bus_a.busy, 2'b00);
`endif
    @(posedge clk);
    #3 async_nreset = 1'b1;
    repeat (3) tick();
    // clean press and release on bit0
    bus_a.signal_in = 2'b01;
    for (int k = 0; k <= 5; k++) begin
      tick();
      check($sformatf("press E%0d", k), bus_a.signal_out, (k == 5) ? 2'b01 : 2'b00);
`ifdef INPUT_DEBOUNCER_BUSY_EN
      check($sformatf("press busy E%0d", k), bus_a.busy, (k >= 2 && k <= 4) ? 2'b01 : 2'b00);
`endif
    end
    bus_a.signal_in = 2'b00;
    for (int k = 0; k <= 5; k++) begin
      tick();
      check($sformatf("release E%0d", k), bus_a.signal_out, (k == 5) ? 2'b00 : 2'b01);
    end
    repeat (3) tick();
    // bounce 1,0,1,0 then held 1
    rises = 0;
    prev = bus_a.signal_out[0];
    for (int k = 0; k <= 11; k++) begin
      bus_a.signal_in = {1'b0, (k < 4) ? (k % 2 == 0) : 1'b1};
      tick();
      check($sformatf("bounce E%0d", k), {31'd0, bus_a.signal_out[0]}, (k >= 9) ? 1 : 0);
      if (!prev && bus_a.signal_out[0]) rises++;
      prev = bus_a.signal_out[0];
    end
    check("bounce rises", rises, 1);
    bus_a.signal_in = 2'b00;
    repeat (8) tick();
    check("bounce settled", bus_a.signal_out, 2'b00);
    // 3-cycle glitch on bit1
    for (int k = 0; k <= 9; k++) begin
      bus_a.signal_in = {k < 3, 1'b0};
      tick();
      check($sformatf("glitch E%0d", k), bus_a.signal_out, 2'b00);
`ifdef INPUT_DEBOUNCER_BUSY_EN
      check($sformatf("glitch busy E%0d", k), bus_a.busy, (k >= 2 && k <= 4) ? 2'b10 : 2'b00);
`endif
    end
    // independent channels, bit1 two cycles behind bit0
    for (int k = 0; k <= 8; k++) begin
      bus_a.signal_in = {k >= 2, 1'b1};
      tick();
      check($sformatf("indep E%0d", k), bus_a.signal_out, {k >= 7, k >= 5});
    end
    bus_a.signal_in = 2'b10;
    for (int k = 0; k <= 5; k++) begin
      tick();
      check($sformatf("indep rel E%0d", k), bus_a.signal_out, {1'b1, k < 5});
    end
    // STABLE_CYCLES=1: held change, then a 1-cycle pulse on bit1
    bus_b.signal_in = 2'b01;
    for (int k = 0; k <= 3; k++) begin
      tick();
      check($sformatf("sc1 held E%0d", k), bus_b.signal_out, (k >= 2) ? 2'b01 : 2'b00);
    end
    for (int k = 0; k <= 4; k++) begin
      bus_b.signal_in = {k == 0, 1'b1};
      tick();
      check($sformatf("sc1 pulse E%0d", k), bus_b.signal_out, {k == 2, 1'b1});
`ifdef INPUT_DEBOUNCER_BUSY_EN
      check($sformatf("sc1 busy E%0d", k), bus_b.busy, 2'b00);
`endif
    end
    // reset mid-count on bit0 while bit1 is already high at the output
    bus_a.signal_in = 2'b11;
    repeat (4) tick();
    check("pre-reset out", bus_a.signal_out, 2'b10);
    #2 async_nreset = 1'b0;
    #1;
    check("async reset out_a", bus_a.signal_out, 2'b00);
    check("async reset out_b", bus_b.signal_out, 2'b00);
`ifdef INPUT_DEBOUNCER_BUSY_EN
    check("async reset busy", bus_a.busy, 2'b00);
`endif
    @(posedge clk);
    #3 async_nreset = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      tick();
      check($sformatf("post-reset R%0d", k), bus_a.signal_out, (k == 6) ? 2'b11 : 2'b00);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
